// File: rtl/clock_pkg.sv
// Shared constants for the clock display controller: FSM encoding and BCD field limits.
package clock_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] SET_HR = 2'd1;
  localparam logic [1:0] SET_MN = 2'd2;

  localparam int HR_MAX_T          = 2;
  localparam int HR_MAX_O_AT_MAX_T = 3;
  localparam int MS_MAX_T          = 5;
  localparam int O_MAX             = 9;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter; wraps to 00 after MAX_T / MAX_O_AT_MAX_T.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX_T          = 5,
  parameter int MAX_O_AT_MAX_T = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic at_max_t;
  logic at_max;
  logic ones_wrap;

  assign at_max_t  = (tens == 3'(MAX_T));
  assign at_max    = at_max_t && (ones == 4'(MAX_O_AT_MAX_T));
  // Below the top tens digit the ones digit runs the full 0-9 range.
  assign ones_wrap = at_max_t ? at_max : (ones == 4'(O_MAX));
  assign carry     = inc && at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones_wrap) begin
        ones <= '0;
        tens <= at_max_t ? 3'd0 : tens + 3'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-keeping and time-set controller: 1 Hz prescaler, two-button set FSM
// and the enable-driven BCD chain for hh:mm:ss.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [2:0] hr_t,
  output logic [3:0] hr_o,
  output logic [2:0] mn_t,
  output logic [3:0] mn_o,
  output logic [2:0] sc_t,
  output logic [3:0] sc_o,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

  logic [1:0]    mode_sync_reg;
  logic [1:0]    inc_sync_reg;
  logic          mode_prev_reg;
  logic          inc_prev_reg;
  logic          mpulse;
  logic          ipulse;
  logic [PW-1:0] pre_reg;
  logic [PW-1:0] pre_next;
  logic [1:0]    mode_next;
  logic          tick;
  logic          exit_set;
  logic          edit_inc;
  logic          sc_inc;
  logic          mn_inc;
  logic          hr_inc;
  logic          sc_carry;
  logic          mn_carry;
  logic          hr_carry_unused;

  // Pulses are registered so the FSM sees a clean single-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_sync_reg <= '0;
      inc_sync_reg  <= '0;
      mode_prev_reg <= 1'b0;
      inc_prev_reg  <= 1'b0;
      mpulse        <= 1'b0;
      ipulse        <= 1'b0;
    end else begin
      mode_sync_reg <= {mode_sync_reg[0], btn_mode};
      inc_sync_reg  <= {inc_sync_reg[0], btn_inc};
      mode_prev_reg <= mode_sync_reg[1];
      inc_prev_reg  <= inc_sync_reg[1];
      mpulse        <= mode_sync_reg[1] & ~mode_prev_reg;
      ipulse        <= inc_sync_reg[1] & ~inc_prev_reg;
    end
  end

  assign tick     = (pre_reg == PRE_LAST);
  assign exit_set = mpulse && (mode == SET_MN);
  assign edit_inc = ipulse && !mpulse;

  always_comb begin
    mode_next = mode;
    if (mpulse) begin
      case (mode)
        RUN:     mode_next = SET_HR;
        SET_HR:  mode_next = SET_MN;
        default: mode_next = RUN;
      endcase
    end
  end

  // Leaving minute-set restarts the second so the new time starts cleanly.
  assign pre_next = (tick || exit_set) ? '0 : pre_reg + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_reg <= '0;
      mode    <= RUN;
      blink   <= 1'b0;
    end else begin
      pre_reg <= pre_next;
      mode    <= mode_next;
      blink   <= (mode_next != RUN) && (pre_next < PRE_HALF);
    end
  end

  assign sc_inc = (mode == RUN) && tick;
  assign mn_inc = sc_carry || ((mode == SET_MN) && edit_inc);
  // Minute carry only propagates while running; editing minutes leaves hours alone.
  assign hr_inc = ((mode == RUN) && mn_carry) || ((mode == SET_HR) && edit_inc);

  bcd_mod_counter #(.MAX_T(MS_MAX_T), .MAX_O_AT_MAX_T(O_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(sc_inc), .clr(exit_set),
    .tens(sc_t), .ones(sc_o), .carry(sc_carry)
  );

  bcd_mod_counter #(.MAX_T(MS_MAX_T), .MAX_O_AT_MAX_T(O_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(mn_inc), .clr(1'b0),
    .tens(mn_t), .ones(mn_o), .carry(mn_carry)
  );

  bcd_mod_counter #(.MAX_T(HR_MAX_T), .MAX_O_AT_MAX_T(HR_MAX_O_AT_MAX_T)) u_hour (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0),
    .tens(hr_t), .ones(hr_o), .carry(hr_carry_unused)
  );

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with a fast prescaler (TICK_DIV=4).
module tb_clock_set_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] hr_t, mn_t, sc_t;
  logic [3:0] hr_o, mn_o, sc_o;
  logic [1:0] mode;
  logic       blink;

  clock_set_ctrl #(.TICK_DIV(TICK_DIV), .PW(3)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_t(hr_t), .hr_o(hr_o), .mn_t(mn_t), .mn_o(mn_o),
    .sc_t(sc_t), .sc_o(sc_o), .mode(mode), .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation layout: mode[23:22] hr[21:15] mn[14:8] sc[7:1] blink[0]
  localparam logic [23:0] M_ALL  = 24'hFFFFFF;
  localparam logic [23:0] M_MODE = 24'hC00000;
  localparam logic [23:0] M_HR   = 24'h3F8000;
  localparam logic [23:0] M_MN   = 24'h007F00;
  localparam logic [23:0] M_SC   = 24'h0000FE;

  typedef struct {
    logic [23:0] val;
    logic [23:0] mask;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference state of the clock as the spec describes it.
  int ph = 0, m_hr = 0, m_mn = 0, m_sc = 0, m_mode = 0;

  function automatic logic [23:0] pack(int md, int h, int m, int s, int b);
    return {md[1:0], 3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), b[0]};
  endfunction

  function automatic logic [23:0] obs();
    return {mode, hr_t, hr_o, mn_t, mn_o, sc_t, sc_o, blink};
  endfunction

  function automatic logic [23:0] model_exp();
    int b;
    b = (m_mode != 0 && ph < TICK_DIV / 2) ? 1 : 0;
    return pack(m_mode, m_hr, m_mn, m_sc, b);
  endfunction

  task automatic step();
    @(posedge clk);
    if (m_mode == 0 && ph == TICK_DIV - 1) begin
      if (m_sc == 59) begin
        m_sc = 0;
        if (m_mn == 59) begin
          m_mn = 0;
          m_hr = (m_hr == 23) ? 0 : m_hr + 1;
        end else m_mn++;
      end else m_sc++;
    end
    ph = (ph == TICK_DIV - 1) ? 0 : ph + 1;
    #1;
  endtask

  // Button effect lands on the 4th edge after the level is driven.
  task automatic press(input bit do_mode, input bit do_inc, input int hold);
    btn_mode = do_mode;
    btn_inc  = do_inc;
    repeat (4) step();
    if (do_mode) begin
      if (m_mode == 2) begin
        m_sc = 0;
        ph   = 0;
      end
      m_mode = (m_mode == 2) ? 0 : m_mode + 1;
    end else if (do_inc) begin
      if (m_mode == 1) m_hr = (m_hr + 1) % 24;
      else if (m_mode == 2) m_mn = (m_mn + 1) % 60;
    end
    repeat (hold) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    #1 rst = 1'b0;
    #1;
    sb.push_back('{pack(0, 0, 0, 0, 0), M_ALL, "reset_state"});
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    #1 rst = 1'b1;
    repeat (10) step();
    #2 rst = 1'b0;
    m_hr = 0; m_mn = 0; m_sc = 0; m_mode = 0; ph = 0;
    sb.push_back('{pack(0, 0, 0, 0, 0), M_ALL, "async_reset"});
    #1;
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    #1 rst = 1'b1;
    for (int i = 1; i <= 4; i++)
      sb.push_back('{pack(0, 0, 0, (i == 4) ? 1 : 0, 0), M_SC, $sformatf("first_tick_e%0d", i)});
    for (int i = 0; i < 4; i++) begin
      step();
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
  endtask

  task automatic test_set_path();
    exp_t e;
    btn_mode = 1'b1;
    for (int i = 1; i <= 4; i++)
      sb.push_back('{pack((i == 4) ? 1 : 0, 0, 0, 0, 0), M_MODE, $sformatf("mode_lat_e%0d", i)});
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) m_mode = 1;
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      sb.push_back('{model_exp(), M_ALL, $sformatf("mode_held_%0d", i)});
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
    btn_mode = 1'b0;
    repeat (3) step();
    sb.push_back('{pack(1, 21, 0, 0, 0), M_MODE | M_HR | M_MN, "hr_at_21"});
    repeat (21) press(1'b0, 1'b1, 0);
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    sb.push_back('{pack(1, 22, 0, 0, 0), M_MODE | M_HR | M_MN, "hr_inc_22"});
    sb.push_back('{pack(1, 23, 0, 0, 0), M_MODE | M_HR | M_MN, "hr_inc_23"});
    sb.push_back('{pack(1, 0, 0, 0, 0), M_MODE | M_HR | M_MN, "hr_wrap_00"});
    sb.push_back('{pack(1, 1, 0, 0, 0), M_MODE | M_HR | M_MN, "hr_inc_01"});
    sb.push_back('{pack(1, 2, 0, 0, 0), M_MODE | M_HR | M_MN, "hr_inc_02"});
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1, 0);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
    repeat (21) press(1'b0, 1'b1, 0);
    sb.push_back('{pack(2, 23, 0, 0, 0), M_MODE | M_HR | M_MN, "enter_set_mn"});
    press(1'b1, 1'b0, 0);
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
  endtask

  task automatic test_minute_set();
    exp_t e;
    repeat (59) press(1'b0, 1'b1, 0);
    sb.push_back('{pack(2, 23, 59, 0, 0), M_MODE | M_HR | M_MN, "mn_at_59"});
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    sb.push_back('{pack(2, 23, 0, 0, 0), M_MODE | M_HR | M_MN, "mn_wrap_no_carry"});
    press(1'b0, 1'b1, 0);
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    for (int i = 0; i < 12; i++) begin
      step();
      sb.push_back('{model_exp(), M_ALL, $sformatf("idle_blink_%0d", i)});
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
    repeat (59) press(1'b0, 1'b1, 0);
    btn_mode = 1'b1;
    sb.push_back('{pack(0, 23, 59, 0, 0), M_ALL, "exit_to_run"});
    repeat (4) step();
    m_mode = 0; m_sc = 0; ph = 0;
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    btn_mode = 1'b0;
    for (int i = 1; i <= 4; i++)
      sb.push_back('{pack(0, 0, 0, (i == 4) ? 1 : 0, 0), M_SC, $sformatf("restart_e%0d", i)});
    for (int i = 0; i < 4; i++) begin
      step();
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
  endtask

  task automatic test_rollover();
    exp_t e;
    repeat (57 * TICK_DIV) step();
    sb.push_back('{pack(0, 23, 59, 58, 0), M_ALL, "at_23_59_58"});
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    for (int i = 1; i <= 8; i++) begin
      if (i < 4) sb.push_back('{pack(0, 23, 59, 58, 0), M_ALL, $sformatf("roll_e%0d", i)});
      else if (i < 8) sb.push_back('{pack(0, 23, 59, 59, 0), M_ALL, $sformatf("roll_e%0d", i)});
      else sb.push_back('{pack(0, 0, 0, 0, 0), M_ALL, "roll_midnight"});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
      end else $display("check %s ok", e.tag);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    btn_mode = 1'b1;
    sb.push_back('{pack(1, 0, 0, 1, 1), M_ALL, "mode_with_tick"});
    repeat (4) step();
    m_mode = 1;
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    btn_mode = 1'b0;
    repeat (3) step();
    sb.push_back('{pack(2, 0, 0, 1, 0), M_MODE | M_HR | M_MN | M_SC, "mode_beats_inc"});
    press(1'b1, 1'b1, 0);
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
    press(1'b1, 1'b0, 0);
    sb.push_back('{pack(0, 0, 0, 2, 0), M_ALL, "inc_ignored_in_run"});
    press(1'b0, 1'b1, 0);
    e = sb.pop_front(); checks++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      errors++; $display("FAIL %s: got %h expected %h", e.tag, obs() & e.mask, e.val & e.mask);
    end else $display("check %s ok", e.tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_set_path();
    test_minute_set();
    test_rollover();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
